rv32_mem_arbiter: RTL and testbench
===================================

# rv32_mem_arbiter

Shares one single-port memory bus between the core's instruction-fetch requester (I-side, read-only) and data requester (D-side, read/write). It enables a unified-memory build of the RV32I core in which fetch and load/store cannot be serviced in the same cycle. It arbitrates round-robin and carries each access over a variable-latency req/ack memory handshake. It returns per-side read data with a one-cycle ready pulse, and aborts with an error when a memory timeout expires.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max BUSY cycles without m_ack before abort; 0 disables timeout
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  I-side request; held with i_addr stable until i_ready
- i_addr  in  AW  I-side read address
- i_ready  out  1  one-cycle pulse: I access complete, i_rdata/err valid
- i_rdata  out  DW  I-side read data register
- d_req  in  1  D-side request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  D-side write enable (1=store, 0=load)
- d_addr  in  AW  D-side address
- d_wdata  in  DW  D-side store data
- d_ready  out  1  one-cycle pulse: D access complete
- d_rdata  out  DW  D-side read data register
- err  out  1  valid with i_ready/d_ready; 1 = access timed out
- m_req  out  1  memory request, held until m_ack or abort
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_ack  in  1  memory completion; m_rdata valid in the same cycle
- m_rdata  in  DW  memory read data
- owner  out  1  current grant: 0=I, 1=D; meaningful only when m_req=1

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- IDLE: if only one req is high, grant it. If both are high, grant the side not granted last; last_grant resets to D, so I wins the first tie. On grant, latch owner, addr, we (I-side forces we=0) and wdata into output registers, update last_grant, and go to BUSY. With no req, stay in IDLE.
- BUSY: m_req=1 with the latched fields. On m_ack, capture m_rdata into the owner's rdata register (writes still capture; the value is don't-care to the requester), set err=0, go to RESP. The other side's rdata register is unchanged.
- Timeout: a wait counter clears on entry to BUSY and increments each BUSY cycle without m_ack. When TIMEOUT≠0 and the count reaches TIMEOUT, abort: rdata register ← 0, err=1, go to RESP. m_ack in the abort cycle takes precedence and gives a normal completion.
- RESP: m_req=0. Pulse the owner's ready for exactly this cycle; err is valid with it. Next state is IDLE.
- Req high in IDLE is a new request. A requester that keeps req high after its ready pulse issues a back-to-back access.
- Req dropped while BUSY is a protocol violation. The arbiter still completes the access and issues the ready pulse.
- m_ack outside BUSY is ignored.

## Timing
- Reset values: m_req=0, m_we=0, m_addr=0, m_wdata=0, owner=0, i_ready=0, d_ready=0, err=0, i_rdata=0, d_rdata=0, state=IDLE, last_grant=D, counter=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Req sampled high in IDLE at edge N → m_req=1 from cycle N+1.
- m_ack high in cycle k → m_req low and ready=1 in cycle k+1 → IDLE in k+2.
- Zero-wait memory (m_ack in the first BUSY cycle): 3 cycles per access (IDLE, BUSY, RESP). Sustained alternating I/D traffic gets one grant each per 6 cycles.
- A timeout abort happens in the TIMEOUT-th BUSY cycle; ready/err follow in the next cycle.
- Reset asserted mid-access: m_req drops asynchronously, no ready pulse is issued, and the in-flight access is lost.

## Test plan
- I-only read, addr 0x0000_0010, m_ack in the 1st BUSY cycle with m_rdata 0x0000_0093 → m_req for 1 cycle with m_we=0; i_ready pulse 1 cycle later with i_rdata=0x93, err=0; d_ready stays 0.
- D store, addr 0x100, wdata 0xCAFE_F00D, ack after 3 wait cycles → m_we=1, m_addr=0x100, m_wdata=0xCAFE_F00D held 4 cycles; d_ready pulses once.
- Both reqs high continuously after reset, zero-wait memory → grant order I, D, I, D; each ready pulse goes to the correct side; rdata registers never cross.
- TIMEOUT=4, D load, m_ack never asserted → abort on the 4th BUSY cycle; next cycle d_ready=1, err=1, d_rdata=0; next grant proceeds normally.
- Reset pulsed during BUSY → all outputs return to reset values asynchronously. After release, the first tie goes to I.
- Spurious m_ack while IDLE, and d_req dropped mid-BUSY → the spurious ack has no effect; the dropped request still completes with one d_ready pulse.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: round-robin arbiter sharing one single-port memory bus
// between the instruction-fetch side (read-only) and the data side
// (read/write). Each access is carried over a req/ack handshake with an
// optional timeout; completion is signalled by a one-cycle ready pulse.
module rv32_mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    // instruction side
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    // data side
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    // memory bus
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;   // 0 = I, 1 = D
    logic [31:0] wait_cnt;     // BUSY cycles elapsed without m_ack
    logic        grant_d;
    logic        timeout_hit;

    // Arbitration and timeout decode from current requests and registered state
    always_comb begin
        grant_d     = 1'b0;
        timeout_hit = 1'b0;
        // D wins when alone, or on a tie when I was granted last
        grant_d = d_req && (!i_req || (last_grant == 1'b0));
        // the abort fires in the TIMEOUT-th BUSY cycle, i.e. when the count
        // of earlier ack-less cycles equals TIMEOUT-1
        if (TIMEOUT != 0) begin
            timeout_hit = (wait_cnt == (TIMEOUT - 32'd1));
        end
    end

    // Control FSM with all bus and response outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            owner      <= 1'b0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            err        <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state    <= BUSY;
                        m_req    <= 1'b1;
                        wait_cnt <= '0;
                        if (grant_d) begin
                            owner      <= 1'b1;
                            m_we       <= d_we;
                            m_addr     <= d_addr;
                            m_wdata    <= d_wdata;
                            last_grant <= 1'b1;
                        end else begin
                            owner      <= 1'b0;
                            m_we       <= 1'b0;
                            m_addr     <= i_addr;
                            m_wdata    <= '0;
                            last_grant <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (m_ack) begin
                        // ack beats a simultaneous timeout
                        state   <= RESP;
                        m_req   <= 1'b0;
                        err     <= 1'b0;
                        i_ready <= ~owner;
                        d_ready <= owner;
                        if (owner) begin
                            d_rdata <= m_rdata;
                        end else begin
                            i_rdata <= m_rdata;
                        end
                    end else if (timeout_hit) begin
                        state   <= RESP;
                        m_req   <= 1'b0;
                        err     <= 1'b1;
                        i_ready <= ~owner;
                        d_ready <= owner;
                        if (owner) begin
                            d_rdata <= '0;
                        end else begin
                            i_rdata <= '0;
                        end
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed scoreboard bench for rv32_mem_arbiter (built with TIMEOUT=4).
module tb_rv32_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        owner;

    rv32_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        side;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          mem_lat = -1;     // wait cycles before ack; negative = never
    bit          force_ack = 1'b0; // spurious ack while the bus is idle
    int          busy_seen = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10) return 32'h93;
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory responder: acks after mem_lat wait cycles with mem_val data
    initial begin
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (mem_lat >= 0 && busy_seen == mem_lat) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_val(m_addr);
                end else begin
                    m_ack   = 1'b0;
                    m_rdata = 32'hDEAD_BEEF;
                end
                busy_seen++;
            end else begin
                busy_seen = 0;
                m_ack     = force_ack;
                m_rdata   = force_ack ? 32'h1234_5678 : 32'h0;
            end
        end
    end

    // response monitor: every ready pulse pops the scoreboard
    always @(negedge clk) begin
        if (!reset && (i_ready || d_ready)) begin
            check("ready_exclusive", {31'b0, i_ready & d_ready}, 32'd0);
            check("ready_expected", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("ready_side", {31'b0, d_ready}, {31'b0, mon_e.side});
                if (mon_e.side) exp_d = mon_e.rdata;
                else            exp_i = mon_e.rdata;
                check("resp_err", {31'b0, err}, {31'b0, mon_e.err});
                check("i_rdata", i_rdata, exp_i);
                check("d_rdata", d_rdata, exp_d);
            end
        end
    end

    task automatic do_access(input logic side, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat);
        exp_t e;
        int   mcyc = 0;
        bit   seen = 1'b0;
        bit   normal;
        normal  = (lat >= 0) && (lat < TO);
        mem_lat = lat;
        e.side  = side;
        e.err   = !normal;
        e.rdata = normal ? mem_val(addr) : 32'h0;
        sb.push_back(e);
        if (side) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (m_req) begin
                mcyc++;
                check("m_we", {31'b0, m_we}, {31'b0, we & side});
                check("m_addr", m_addr, addr);
                check("owner", {31'b0, owner}, {31'b0, side});
                if (side && we) check("m_wdata", m_wdata, wdata);
            end
            if (side ? d_ready : i_ready) seen = 1'b1;
        end
        check("ready_seen", {31'b0, seen}, 32'd1);
        check("m_req_cycles", mcyc, normal ? lat + 1 : TO);
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        check("idle_m_req", {31'b0, m_req}, 32'd0);
        check("ready_cleared", {31'b0, i_ready | d_ready}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   grants;
        int   pulses;
        int   done_cyc;
        logic prev_mreq;

        // reset values
        #1 reset = 1'b1;
        #1;
        check("rst_m_req", {31'b0, m_req}, 32'd0);
        check("rst_m_we", {31'b0, m_we}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_owner", {31'b0, owner}, 32'd0);
        check("rst_i_ready", {31'b0, i_ready}, 32'd0);
        check("rst_d_ready", {31'b0, d_ready}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // single accesses: read, store with ack in the abort cycle,
        // timeout, recovery, ack one cycle too late
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0);
        do_access(1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 3);
        do_access(1'b1, 1'b0, 32'h0000_0180, 32'h0, -1);
        do_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1);
        do_access(1'b1, 1'b0, 32'h0000_01C0, 32'h0, 4);
        do_access(1'b1, 1'b0, 32'h0000_0140, 32'h0, 2);

        // reset in the middle of an access
        mem_lat = -1;
        i_req = 1'b1; i_addr = 32'h40;
        tick();
        check("mid_m_req", {31'b0, m_req}, 32'd1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_m_req", {31'b0, m_req}, 32'd0);
        check("arst_m_addr", m_addr, 32'd0);
        check("arst_d_rdata", d_rdata, 32'd0);
        check("arst_i_rdata", i_rdata, 32'd0);
        check("arst_err", {31'b0, err}, 32'd0);
        exp_i = '0; exp_d = '0;
        i_req = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();
        check("arst_no_ready", {31'b0, i_ready | d_ready}, 32'd0);

        // both sides held high: alternate I, D, I, D from reset
        mem_lat = 0;
        i_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.side  = k[0];
            e.rdata = k[0] ? mem_val(32'h400) : mem_val(32'h300);
            e.err   = 1'b0;
            sb.push_back(e);
        end
        i_req = 1'b1; d_req = 1'b1;
        grants = 0; pulses = 0; done_cyc = 0; prev_mreq = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (m_req && !prev_mreq) begin
                check("grant_order", {31'b0, owner}, grants % 2);
                grants++;
            end
            prev_mreq = m_req;
            if (i_ready || d_ready) pulses++;
            if (pulses == 4) begin
                done_cyc = c;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        check("rr_pulses", pulses, 32'd4);
        check("rr_grants", grants, 32'd4);
        check("rr_cycles", done_cyc, 32'd11);
        tick();
        check("rr_sb_drained", sb.size(), 32'd0);

        // spurious ack while idle
        force_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("spur_m_req", {31'b0, m_req}, 32'd0);
            check("spur_ready", {31'b0, i_ready | d_ready}, 32'd0);
        end
        force_ack = 1'b0;
        check("spur_i_rdata", i_rdata, exp_i);
        check("spur_d_rdata", d_rdata, exp_d);

        // d_req dropped while BUSY still completes once
        mem_lat = 2;
        e.side = 1'b1; e.rdata = mem_val(32'h500); e.err = 1'b0;
        sb.push_back(e);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        check("drop_m_req", {31'b0, m_req}, 32'd1);
        tick();
        d_req = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (d_ready) pulses++;
        end
        check("drop_pulses", pulses, 32'd1);
        check("drop_sb_drained", sb.size(), 32'd0);
        check("drop_idle", {31'b0, m_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
